tbu_param: RTL and testbench
============================

Name: tbu_param

Overview:
Parametrised traceback unit for the Viterbi decoder. Generalised over constraint length K, traceback (merge) depth and decode block length.
- Consumes survivor decision vectors newest-first from the survivor memory, starting at a caller-supplied state.
- Runs TB_LEN merge steps with no output, then DEC_LEN decode steps.
- Reverses the decoded bits in an internal LIFO and streams them out in chronological order over a valid/ready handshake.

Parameters:
K, 4, constraint length (K >= 3); M = K-1 state bits, S = 2^M states
TB_LEN, 16, merge steps per block (>= 1); bits not emitted
DEC_LEN, 16, decode steps per block (>= 1); bits emitted per block

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
enable  in  1  synchronous clear when low: FSM to IDLE, outputs to reset values
start  in  1  one-cycle pulse; starts a block; honoured only in IDLE
start_state  in  M  traceback start state (caller passes best-metric state or 0), sampled with start
dec_valid  in  1  decision vector valid
dec_ready  out  1  block accepts a decision vector
dec_vec  in  S  decision bits; bit s = survivor decision of state s
out_valid  out  1  decoded bit valid
out_ready  in  1  downstream accepts decoded bit
out_bit  out  1  decoded bit, chronological order
out_last  out  1  marks final bit of block
busy  out  1  high in any state other than IDLE

Behaviour:
- Trellis convention: state = last M inputs, newest at MSB.
  - Decoded bit of state s = s[M-1].
  - Predecessor of s given decision d = {s[M-2:0], d}, with d = dec_vec[s].
- Reset (rst low) and enable low give identical results:
  - FSM in IDLE; pstate, counters and LIFO pointer = 0.
  - out_valid = out_bit = out_last = dec_ready = busy = 0.
- enable low mid-block: the block is abandoned and partial LIFO contents are discarded. enable has priority over start.
- FSM states:
  - IDLE: dec_ready = 0. When start = 1: pstate <= start_state, cnt <= 0, go to MERGE.
  - MERGE: dec_ready = 1. On each dec_valid & dec_ready: pstate <= pred(pstate, dec_vec[pstate]), cnt++. After TB_LEN accepted vectors: cnt <= 0, go to DECODE.
  - DECODE: dec_ready = 1. On each accepted vector:
    - write pstate[M-1] to LIFO[cnt];
    - pstate <= pred(pstate, dec_vec[pstate]);
    - cnt++.
    - After DEC_LEN accepted vectors: go to FLUSH, rd_ptr <= DEC_LEN-1.
  - FLUSH: dec_ready = 0. Outputs are registered:
    - out_valid = 1, out_bit = LIFO[rd_ptr], out_last = (rd_ptr == 0).
    - On out_valid & out_ready: rd_ptr-- and the next bit is presented the following cycle.
    - When the last bit is accepted: out_valid <= 0, go to IDLE.
- No step without handshake: dec_valid low stalls cnt and pstate; out_ready low holds out_bit/out_last stable.
- Latency: first out_valid appears 1 cycle after the last DECODE vector is accepted.
  - Minimum block period = 1 + TB_LEN + DEC_LEN + DEC_LEN cycles, plus the return to IDLE.
- Ordering: out_bit sequence = decode-step bits in reverse traceback order, i.e. oldest information bit first.
- start is ignored outside IDLE; start and first dec_valid may share a cycle, but the vector is not accepted until MERGE.
- Widths: cnt and rd_ptr are $clog2(max(TB_LEN, DEC_LEN)+1) bits. Indexing dec_vec uses the full M-bit pstate, so there is no out-of-range case.

Decomposition:
- Package tbu_pkg:
  - FSM state enum {IDLE, MERGE, DECODE, FLUSH};
  - function pred_state(state, decision, M);
  - function state_bit(state, M).
- Sub-module tbu_lifo (DEPTH = DEC_LEN, 1-bit wide): indexed write, indexed read, synchronous clear. The top holds the FSM, pstate and counters.

Test Plan:
- K=3, TB_LEN=1, DEC_LEN=4, start_state=2'b11, dec_vec=4'b0000 ×5 -> merge 11→10; decode emits 1,0,0,0 -> out_bit 0,0,0,1, out_last with final 1.
- K=3, start_state=2'b11, dec_vec=4'b1111 ×5 -> pstate stays 11; out_bit 1,1,1,1; busy low again after final accept.
- Defaults, start_state=0, all-zero vectors, out_ready toggling every other cycle -> 16 zeros, out_bit stable while stalled, exactly one out_last.
- dec_valid gapped (1 of 3 cycles) -> identical output to gapless run; dec_ready low in IDLE and FLUSH.
- enable low for 1 cycle mid-DECODE (cnt=2) -> FSM IDLE, out_valid 0, busy 0; a following block decodes correctly with no stale bits.
- start pulsed during FLUSH -> ignored; rst asserted in MERGE -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/tbu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tbu_pkg
// Description : Shared types and trellis helpers for the Viterbi traceback
//               unit. The trellis state holds the last M inputs with the
//               newest input in the MSB.
// Contents    : tbu_state_e - traceback FSM states
//               pred_state  - predecessor state given a survivor decision
//               state_bit   - information bit carried by a state
// Revision    : 1.0 - initial release
// ============================================================================
package tbu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MERGE  = 2'd1,
        DECODE = 2'd2,
        FLUSH  = 2'd3
    } tbu_state_e;

    // Predecessor of a state: drop the newest bit (MSB) and shift the
    // survivor decision in at the LSB, i.e. {state[m-2:0], decision}.
    // Carried in 32 bits so one function serves every state width.
    function automatic logic [31:0] pred_state(input logic [31:0] state,
                                               input logic        decision,
                                               input int          m);
        logic [31:0] mask;
        mask = (32'd1 << m) - 32'd1;
        return ((state << 1) | {31'd0, decision}) & mask;
    endfunction

    // Information bit represented by a state: its MSB, state[m-1].
    function automatic logic state_bit(input logic [31:0] state,
                                       input int          m);
        logic [31:0] shifted;
        shifted = state >> (m - 1);
        return shifted[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/tbu_lifo.sv
`default_nettype none
// ============================================================================
// Module      : tbu_lifo
// Description : 1-bit wide reversal store for decoded bits. Written at an
//               index during traceback, read at an index during flush.
// Ports       : clk    - clock
//               rst    - asynchronous active-low reset
//               clr    - synchronous clear of all entries
//               we     - write enable
//               waddr  - write index
//               wdata  - write bit
//               raddr  - read index (combinational read)
//               rdata  - read bit
// Revision    : 1.0 - initial release
// ============================================================================
module tbu_lifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic          wdata,
    input  logic [AW-1:0] raddr,
    output logic          rdata
);

    logic [DEPTH-1:0] mem_q;
    logic [DEPTH-1:0] mem_d;

    // Per-entry next value; the index comparison keeps the address width
    // independent of DEPTH (the counter is sized for the longer phase).
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            assign mem_d[i] = clr ? 1'b0 :
                              ((we && (waddr == AW'(i))) ? wdata : mem_q[i]);
        end
    endgenerate

    always_comb begin
        rdata = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr == AW'(i)) begin
                rdata = mem_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tbu_param.sv
`default_nettype none
// ============================================================================
// Module      : tbu_param
// Description : Parametrised Viterbi traceback unit. Walks the survivor
//               decisions newest-first from a supplied start state, discards
//               TB_LEN merge steps, records DEC_LEN decoded bits and streams
//               them out oldest-first over a valid/ready handshake.
// Ports       : clk, rst (async, active-low), enable (sync clear when low)
//               start/start_state  - block start and traceback start state
//               dec_valid/dec_ready/dec_vec - survivor decision vectors in
//               out_valid/out_ready/out_bit/out_last - decoded bit stream
//               busy - high whenever not idle
// Revision    : 1.0 - initial release
// ============================================================================
module tbu_param
    import tbu_pkg::*;
#(
    parameter int K       = 4,
    parameter int TB_LEN  = 16,
    parameter int DEC_LEN = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             start,
    input  logic [K-2:0]     start_state,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [(1<<(K-1))-1:0] dec_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last,
    output logic             busy
);

    localparam int M    = K - 1;
    localparam int MAXL = (TB_LEN > DEC_LEN) ? TB_LEN : DEC_LEN;
    localparam int CW   = $clog2(MAXL + 1);

    localparam logic [CW-1:0] TB_LAST  = CW'(TB_LEN - 1);
    localparam logic [CW-1:0] DEC_LAST = CW'(DEC_LEN - 1);

    tbu_state_e    state_q, state_d;
    logic [M-1:0]  pstate_q, pstate_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic          out_valid_q, out_valid_d;
    logic          out_bit_q, out_bit_d;
    logic          out_last_q, out_last_d;
    logic          dec_ready_q, dec_ready_d;
    logic          busy_q, busy_d;

    logic          dec_accept;
    logic          decision;
    logic [M-1:0]  pstate_pred;
    logic          cur_bit;
    logic          lifo_we;
    logic [CW-1:0] lifo_raddr;
    logic          lifo_rdata;

    assign dec_accept  = dec_valid & dec_ready_q;
    assign decision    = dec_vec[pstate_q];
    assign pstate_pred = M'(pred_state(32'(pstate_q), decision, M));
    assign cur_bit     = state_bit(32'(pstate_q), M);
    assign lifo_we     = enable && (state_q == DECODE) && dec_accept;
    // Look one entry ahead so the next bit is ready to register on accept.
    assign lifo_raddr  = rd_ptr_q - CW'(1);

    tbu_lifo #(
        .DEPTH (DEC_LEN),
        .AW    (CW)
    ) u_lifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (!enable),
        .we    (lifo_we),
        .waddr (cnt_q),
        .wdata (cur_bit),
        .raddr (lifo_raddr),
        .rdata (lifo_rdata)
    );

    always_comb begin
        state_d     = state_q;
        pstate_d    = pstate_q;
        cnt_d       = cnt_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_bit_d   = out_bit_q;
        out_last_d  = out_last_q;

        if (!enable) begin
            state_d     = IDLE;
            pstate_d    = '0;
            cnt_d       = '0;
            rd_ptr_d    = '0;
            out_valid_d = 1'b0;
            out_bit_d   = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        pstate_d = start_state;
                        cnt_d    = '0;
                        state_d  = MERGE;
                    end
                end
                MERGE: begin
                    if (dec_accept) begin
                        pstate_d = pstate_pred;
                        if (cnt_q == TB_LAST) begin
                            cnt_d   = '0;
                            state_d = DECODE;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                DECODE: begin
                    if (dec_accept) begin
                        pstate_d = pstate_pred;
                        if (cnt_q == DEC_LAST) begin
                            cnt_d       = '0;
                            state_d     = FLUSH;
                            rd_ptr_d    = DEC_LAST;
                            // The newest bit is being written this cycle, so
                            // present it directly instead of reading it back.
                            out_valid_d = 1'b1;
                            out_bit_d   = cur_bit;
                            out_last_d  = (DEC_LAST == '0);
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (out_valid_q && out_ready) begin
                        if (rd_ptr_q == '0) begin
                            out_valid_d = 1'b0;
                            out_bit_d   = 1'b0;
                            out_last_d  = 1'b0;
                            state_d     = IDLE;
                        end else begin
                            rd_ptr_d   = rd_ptr_q - CW'(1);
                            out_bit_d  = lifo_rdata;
                            out_last_d = (rd_ptr_q == CW'(1));
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Handshake/status flags follow the next state so they are
        // registered alongside it.
        dec_ready_d = (state_d == MERGE) || (state_d == DECODE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pstate_q    <= '0;
            cnt_q       <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
            dec_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pstate_q    <= pstate_d;
            cnt_q       <= cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_last_q  <= out_last_d;
            dec_ready_q <= dec_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign dec_ready = dec_ready_q;
    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_tbu_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_tbu_param
// Description : Directed self-checking bench for tbu_param. A small instance
//               (K=3, TB_LEN=1, DEC_LEN=4) carries the hand-computed trellis
//               vectors; a default instance checks the full-size flush.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tbu_param;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;
    always #5 clk = ~clk;

    logic       a_start, a_dv, a_dr, a_ov, a_or, a_ob, a_ol, a_busy;
    logic [1:0] a_ss;
    logic [3:0] a_vec;

    logic       b_start, b_dv, b_dr, b_ov, b_or, b_ob, b_ol, b_busy;
    logic [2:0] b_ss;
    logic [7:0] b_vec;

    int n_cmp = 0;
    int n_err = 0;

    tbu_param #(.K(3), .TB_LEN(1), .DEC_LEN(4)) u_small (
        .clk(clk), .rst(rst), .enable(enable), .start(a_start),
        .start_state(a_ss), .dec_valid(a_dv), .dec_ready(a_dr),
        .dec_vec(a_vec), .out_valid(a_ov), .out_ready(a_or),
        .out_bit(a_ob), .out_last(a_ol), .busy(a_busy)
    );

    tbu_param u_big (
        .clk(clk), .rst(rst), .enable(enable), .start(b_start),
        .start_state(b_ss), .dec_valid(b_dv), .dec_ready(b_dr),
        .dec_vec(b_vec), .out_valid(b_ov), .out_ready(b_or),
        .out_bit(b_ob), .out_last(b_ol), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One block on the small instance. e[k] is the k-th bit expected on the
    // output stream (oldest first).
    task automatic a_block(input string tag, input logic [1:0] ss,
                           input logic [3:0] v0, input logic [3:0] v1,
                           input logic [3:0] v2, input logic [3:0] v3,
                           input logic [3:0] v4, input logic [3:0] e,
                           input bit gap, input bit toggle,
                           input bit flush_start);
        logic [3:0] vecs [5];
        int   idx, phase, k, guard;
        bit   acc, held;
        logic hold_bit, hold_last;
        vecs = '{v0, v1, v2, v3, v4};
        @(negedge clk);
        a_start = 1'b1; a_ss = ss; a_dv = 1'b0;
        @(negedge clk);
        a_start = 1'b0;
        check({tag, ":ready_merge"}, a_dr, 1);
        check({tag, ":busy_merge"}, a_busy, 1);
        idx = 0; phase = 0; guard = 0;
        while (idx < 5 && guard < 60) begin
            a_dv  = !gap || (phase % 3 == 0);
            a_vec = vecs[idx];
            acc   = a_dv && a_dr;
            @(negedge clk);
            if (acc) idx++;
            phase++; guard++;
        end
        a_dv = 1'b0;
        check({tag, ":vectors_taken"}, idx, 5);
        check({tag, ":valid_latency"}, a_ov, 1);
        check({tag, ":ready_flush"}, a_dr, 0);
        k = 0; guard = 0; held = 0; hold_bit = 0; hold_last = 0;
        while (k < 4 && guard < 40) begin
            if (held) begin
                check({tag, ":stall_bit"}, a_ob, hold_bit);
                check({tag, ":stall_last"}, a_ol, hold_last);
            end
            a_or = toggle ? (guard % 2 == 1) : 1'b1;
            if (flush_start && guard == 0) begin
                a_start = 1'b1; a_ss = 2'b01;
            end else begin
                a_start = 1'b0;
            end
            if (a_ov && a_or) begin
                check({tag, ":bit"}, a_ob, e[k]);
                check({tag, ":last"}, a_ol, (k == 3));
                k++; held = 0;
            end else if (a_ov) begin
                held = 1; hold_bit = a_ob; hold_last = a_ol;
            end
            @(negedge clk);
            guard++;
        end
        a_or = 1'b0; a_start = 1'b0;
        check({tag, ":bits_out"}, k, 4);
        check({tag, ":valid_end"}, a_ov, 0);
        check({tag, ":busy_end"}, a_busy, 0);
        check({tag, ":ready_idle"}, a_dr, 0);
    endtask

    int   bidx, bk, bguard, blasts;
    bit   bacc, bheld;
    logic bhold;

    initial begin
        a_start = 0; a_ss = 0; a_dv = 0; a_vec = 0; a_or = 0;
        b_start = 0; b_ss = 0; b_dv = 0; b_vec = 0; b_or = 0;
        repeat (3) @(negedge clk);
        check("rst:a_valid", a_ov, 0);
        check("rst:a_ready", a_dr, 0);
        check("rst:a_busy", a_busy, 0);
        check("rst:a_bit_last", {a_ob, a_ol}, 0);
        check("rst:b_valid_ready_busy", {b_ov, b_dr, b_busy}, 0);
        rst = 1'b1; enable = 1'b1;
        @(negedge clk);

        // 11 -> merge to 10, decode 1,0,0,0 -> stream 0,0,0,1
        a_block("zeros", 2'b11, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b1000, 0, 0, 0);
        // all-ones decisions hold the state at 11
        a_block("ones", 2'b11, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'b1111, 0, 0, 0);
        // 01 -> 11, decode 1,1,0,1 -> stream 1,0,1,1
        a_block("mixed", 2'b01, 4'b0010, 4'b0000, 4'b0100, 4'b0010, 4'b0000,
                4'b1101, 0, 0, 0);
        a_block("mixed_gap", 2'b01, 4'b0010, 4'b0000, 4'b0100, 4'b0010, 4'b0000,
                4'b1101, 1, 1, 0);
        a_block("flush_start", 2'b11, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b1000, 0, 0, 1);

        // enable low for one cycle mid-DECODE (cnt = 2)
        @(negedge clk);
        a_start = 1'b1; a_ss = 2'b11;
        @(negedge clk);
        a_start = 1'b0; a_dv = 1'b1; a_vec = 4'h0;
        repeat (3) @(negedge clk);
        a_dv = 1'b0;
        check("en:busy_before", a_busy, 1);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        check("en:busy", a_busy, 0);
        check("en:valid", a_ov, 0);
        check("en:ready", a_dr, 0);
        a_block("after_en", 2'b01, 4'b0010, 4'b0000, 4'b0100, 4'b0010, 4'b0000,
                4'b1101, 0, 0, 0);

        // default-size instance: all-zero trellis, stalled output
        @(negedge clk);
        b_start = 1'b1; b_ss = 3'b000;
        @(negedge clk);
        b_start = 1'b0; b_dv = 1'b1; b_vec = 8'h00;
        bidx = 0; bguard = 0;
        while (bidx < 32 && bguard < 200) begin
            bacc = b_dv && b_dr;
            @(negedge clk);
            if (bacc) bidx++;
            bguard++;
        end
        b_dv = 1'b0;
        check("big:vectors_taken", bidx, 32);
        check("big:valid_latency", b_ov, 1);
        bk = 0; bguard = 0; blasts = 0; bheld = 0; bhold = 0;
        while (bk < 16 && bguard < 100) begin
            if (bheld) check("big:stall_bit", b_ob, bhold);
            b_or = (bguard % 2 == 1);
            if (b_ov && b_or) begin
                check("big:bit", b_ob, 0);
                check("big:last", b_ol, (bk == 15));
                if (b_ol) blasts++;
                bk++; bheld = 0;
            end else if (b_ov) begin
                bheld = 1; bhold = b_ob;
            end
            @(negedge clk);
            bguard++;
        end
        b_or = 1'b0;
        check("big:bits_out", bk, 16);
        check("big:one_last", blasts, 1);
        check("big:valid_end", b_ov, 0);
        check("big:busy_end", b_busy, 0);

        // asynchronous reset while in MERGE
        @(negedge clk);
        a_start = 1'b1; a_ss = 2'b10;
        @(negedge clk);
        a_start = 1'b0;
        check("arst:busy_before", a_busy, 1);
        #2 rst = 1'b0;
        #1;
        check("arst:busy", a_busy, 0);
        check("arst:ready", a_dr, 0);
        check("arst:outs", {a_ov, a_ob, a_ol}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("arst:idle_after", a_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
